// File: rtl/serial_paralelo_rx_pkg.sv
// Shared definitions for the serial-to-parallel receive path: alignment character,
// lock threshold defaults and the aligner state encoding.
package serial_paralelo_rx_pkg;

    localparam logic [7:0] COMMA_DEFAULT      = 8'hBC;
    localparam int         ACTIVE_CNT_DEFAULT = 4;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } rx_state_e;

endpackage

// File: rtl/serial_paralelo_rx_if.sv
// Serial bit input plus the byte-level outputs that feed the downstream demux.
// master = bit source / byte consumer, slave = the receiver.
interface serial_paralelo_rx_if;

    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic       byte_stb;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  active,
        input  byte_stb
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output active,
        output byte_stb
    );

endinterface

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver: bit-slides onto COMMA, locks after ACTIVE_CNT aligned commas.
// Latency: byte appears on the edge that samples its last bit; all outputs registered.
// Backpressure: none, the serial stream is free-running and bytes are presented for 8 cycles.
module serial_paralelo_rx
    import serial_paralelo_rx_pkg::*;
#(
    parameter logic [7:0] COMMA      = COMMA_DEFAULT,
    parameter int         ACTIVE_CNT = ACTIVE_CNT_DEFAULT
) (
    input  logic                 clk_32f,
    input  logic                 reset,
    serial_paralelo_rx_if.slave  rx
);

    localparam int CW = (ACTIVE_CNT < 2) ? 1 : $clog2(ACTIVE_CNT + 1);

    rx_state_e       state;
    logic [7:0]      sr;
    logic [2:0]      bit_cnt;
    logic [CW-1:0]   comma_cnt;
    logic [7:0]      data_out;
    logic            valid_out;
    logic            active;
    logic            byte_stb;

    logic [7:0]      window;
    logic            byte_done;

    assign window    = {sr[6:0], rx.data_in};
    assign byte_done = (bit_cnt == 3'd7);

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state     <= SEARCH;
            sr        <= 8'h00;
            bit_cnt   <= 3'd0;
            comma_cnt <= '0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
            active    <= 1'b0;
            byte_stb  <= 1'b0;
        end else begin
            sr       <= window;
            byte_stb <= 1'b0;
            case (state)
                SEARCH: begin
                    // Byte boundary is fixed at the edge where the comma is first seen
                    if (window == COMMA) begin
                        bit_cnt   <= 3'd0;
                        comma_cnt <= CW'(1);
                        if (ACTIVE_CNT <= 1) begin
                            state     <= ACTIVE;
                            active    <= 1'b1;
                            data_out  <= COMMA;
                            valid_out <= 1'b0;
                            byte_stb  <= 1'b1;
                        end else begin
                            state <= ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (byte_done) begin
                        if (window == COMMA) begin
                            comma_cnt <= comma_cnt + CW'(1);
                            if (comma_cnt + CW'(1) == CW'(ACTIVE_CNT)) begin
                                state     <= ACTIVE;
                                active    <= 1'b1;
                                data_out  <= COMMA;
                                valid_out <= 1'b0;
                                byte_stb  <= 1'b1;
                            end
                        end else begin
                            state     <= SEARCH;
                            comma_cnt <= '0;
                        end
                    end
                end
                ACTIVE: begin
                    // Locked: commas straddling byte boundaries are ignored
                    bit_cnt <= bit_cnt + 3'd1;
                    if (byte_done) begin
                        data_out  <= window;
                        valid_out <= (window != COMMA);
                        byte_stb  <= 1'b1;
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

    assign rx.data_out  = data_out;
    assign rx.valid_out = valid_out;
    assign rx.active    = active;
    assign rx.byte_stb  = byte_stb;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Bench for serial_paralelo_rx: directed lock/unlock scenarios plus randomized streams,
// every cycle compared against a bit-stream reference model.
module tb_serial_paralelo_rx;

    localparam int COMMA      = 8'hBC;
    localparam int ACTIVE_CNT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    serial_paralelo_rx_if sif ();

    serial_paralelo_rx #(
        .COMMA      (8'hBC),
        .ACTIVE_CNT (ACTIVE_CNT)
    ) dut (
        .clk_32f (clk),
        .reset   (rst),
        .rx      (sif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: mode 0 hunting, 1 counting commas, 2 locked
    int m_mode, m_win, m_bits, m_commas, m_byte;
    int exp_do, exp_v, exp_act, exp_stb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update(input logic b, input logic r);
        if (r) begin
            m_mode = 0; m_win = 0; m_bits = 0; m_commas = 0;
            exp_do = 0; exp_v = 0; exp_act = 0; exp_stb = 0;
            return;
        end
        exp_stb = 0;
        m_win   = ((m_win * 2) + int'(b)) % 256;
        if (m_mode == 0) begin
            if (m_win == COMMA) begin
                m_commas = 1;
                m_bits   = 0;
                m_mode   = 1;
            end
        end else begin
            m_bits++;
            if (m_bits == 8) begin
                m_bits = 0;
                m_byte = m_win;
                if (m_mode == 1) begin
                    if (m_byte == COMMA) begin
                        m_commas++;
                        if (m_commas == ACTIVE_CNT) begin
                            m_mode  = 2;
                            exp_act = 1;
                            exp_do  = COMMA;
                            exp_v   = 0;
                            exp_stb = 1;
                        end
                    end else begin
                        m_mode   = 0;
                        m_commas = 0;
                    end
                end else begin
                    exp_do  = m_byte;
                    exp_v   = (m_byte != COMMA) ? 1 : 0;
                    exp_stb = 1;
                end
            end
        end
    endtask

    // Inputs change on the falling edge; outputs are compared on the next falling edge
    task automatic step(input logic b, input logic r);
        sif.data_in = b;
        rst         = r;
        @(posedge clk);
        model_update(b, r);
        @(negedge clk);
        chk("data_out",  32'(sif.data_out),  32'(exp_do));
        chk("valid_out", 32'(sif.valid_out), 32'(exp_v));
        chk("active",    32'(sif.active),    32'(exp_act));
        chk("byte_stb",  32'(sif.byte_stb),  32'(exp_stb));
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) step(b[i], 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'($urandom_range(0, 1)), 1'b1);
    endtask

    task automatic send_bcs(input int n);
        for (int i = 0; i < n; i++) send_byte(8'hBC);
    endtask

    initial begin
        logic [7:0] pb;
        logic [7:0] slip;
        int nb;

        sif.data_in = 1'b0;
        @(negedge clk);

        // Lock on clean commas, then a payload byte
        do_reset(2);
        chk("rst data_out", 32'(sif.data_out), 32'h00);
        chk("rst active",   32'(sif.active),   32'h0);
        send_bcs(4);
        chk("lock active",    32'(sif.active),   32'h1);
        chk("lock comma out", 32'(sif.data_out), 32'hBC);
        chk("lock comma stb", 32'(sif.byte_stb), 32'h1);
        send_byte(8'hA5);
        chk("A5 data_out", 32'(sif.data_out),  32'hA5);
        chk("A5 valid",    32'(sif.valid_out), 32'h1);

        // Misaligned start
        do_reset(1);
        slip = 8'hA0;
        send_bits(slip, 3);
        send_bcs(4);
        send_byte(8'h3C);
        chk("3C data_out", 32'(sif.data_out),  32'h3C);
        chk("3C valid",    32'(sif.valid_out), 32'h1);

        // Non-comma during alignment drops back to hunting
        do_reset(1);
        send_bcs(3);
        send_byte(8'h12);
        chk("12 active",   32'(sif.active),   32'h0);
        chk("12 byte_stb", 32'(sif.byte_stb), 32'h0);
        send_bcs(4);
        chk("relock active", 32'(sif.active), 32'h1);
        send_byte(8'h77);
        chk("77 data_out", 32'(sif.data_out), 32'h77);

        // Payload with an embedded comma
        send_byte(8'h01);
        chk("01 valid", 32'(sif.valid_out), 32'h1);
        send_byte(8'hBC);
        chk("BC valid", 32'(sif.valid_out), 32'h0);
        chk("BC data",  32'(sif.data_out),  32'hBC);
        send_byte(8'hFF);
        chk("FF valid", 32'(sif.valid_out), 32'h1);

        // Straddling comma must not realign
        send_byte(8'h0B);
        chk("0B data_out", 32'(sif.data_out), 32'h0B);
        send_byte(8'hC0);
        chk("C0 data_out", 32'(sif.data_out),  32'hC0);
        chk("C0 valid",    32'(sif.valid_out), 32'h1);

        // Reset mid-byte while locked
        send_bits(8'h5A, 4);
        step(1'b1, 1'b1);
        chk("midrst data_out", 32'(sif.data_out),  32'h00);
        chk("midrst valid",    32'(sif.valid_out), 32'h0);
        chk("midrst active",   32'(sif.active),    32'h0);
        send_bcs(3);
        chk("midrst 3bc active", 32'(sif.active), 32'h0);
        send_bcs(1);
        chk("midrst 4bc active", 32'(sif.active), 32'h1);

        // Randomized streams: slips, comma runs of varying length, payload, stray resets
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 3) == 0) do_reset($urandom_range(1, 3));
            slip = 8'($urandom_range(0, 255));
            send_bits(slip, $urandom_range(0, 7));
            send_bcs($urandom_range(2, 5));
            nb = $urandom_range(1, 8);
            for (int j = 0; j < nb; j++) begin
                pb = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 4) == 0) pb = 8'hBC;
                if ($urandom_range(0, 15) == 0) begin
                    send_bits(pb, $urandom_range(1, 7));
                    do_reset(1);
                end else begin
                    send_byte(pb);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_paralelo_rx.md
SERIAL_PARALELO_RX -- requirements
Module: serial_paralelo_rx

Interface
REQ-001 Parameter COMMA, default 8'hBC: idle/alignment character.
REQ-002 Parameter ACTIVE_CNT, default 4: consecutive aligned COMMA bytes needed to enter ACTIVE.
REQ-003 The block SHALL have port clk_32f  input  1  serial bit clock; single clock domain, all logic on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port data_in  input  1  serial bit, MSB of each byte first.
REQ-006 The block SHALL have port data_out  output  8  last completed byte; feeds the downstream byte demux data input.
REQ-007 The block SHALL have port valid_out  output  1  data_out holds a payload byte; feeds the downstream demux valid input.
REQ-008 The block SHALL have port active  output  1  byte alignment locked.
REQ-009 The block SHALL have port byte_stb  output  1  one-cycle pulse when data_out/valid_out update.

Function
REQ-010 The block SHALL sample data_in on every rising edge into an 8-bit shift register; next window = {sr[6:0], data_in}.
REQ-011 The block SHALL implement states SEARCH, ALIGN, ACTIVE.
REQ-012 In SEARCH, the window SHALL be compared against COMMA on every edge (bit-sliding); on match -> ALIGN, comma count = 1, bit counter = 0 (byte boundary set at this edge).
REQ-013 In ALIGN/ACTIVE, the bit counter SHALL count 0..7 and wrap; a byte completes on the edge where the counter goes 7->0, window = completed byte.
REQ-014 In ALIGN, a completed byte equal to COMMA SHALL increment the comma count; on reaching ACTIVE_CNT -> ACTIVE on that same edge.
REQ-015 In ALIGN, a completed byte not equal to COMMA SHALL return to SEARCH with comma count = 0; no outputs change.
REQ-016 In SEARCH/ALIGN, data_out SHALL hold 8'h00, valid_out = 0, byte_stb = 0, active = 0.
REQ-017 active SHALL be 1 from the edge entering ACTIVE until reset; ACTIVE is left only by reset.
REQ-018 In ACTIVE, on each byte completion: data_out <= completed byte; valid_out <= (byte != COMMA); byte_stb <= 1 for exactly one cycle.
REQ-019 The byte that completes the ACTIVE_CNT-th COMMA SHALL produce data_out = COMMA, valid_out = 0, byte_stb = 1.
REQ-020 data_out and valid_out SHALL be held stable for the 8 cycles between byte completions.
REQ-021 Latency: data_out SHALL reflect a byte on the edge that samples its last bit (all outputs registered, no combinational path from data_in).
REQ-022 A COMMA pattern straddling two bytes in ALIGN/ACTIVE SHALL NOT realign the counter.

Reset
REQ-023 When reset = 1 at a rising edge: state = SEARCH, shift register = 0, bit counter = 0, comma count = 0, data_out = 8'h00, valid_out = 0, active = 0, byte_stb = 0.
REQ-024 Reset asserted mid-byte or mid-ALIGN SHALL discard all partial progress; search restarts on the first edge after reset deasserts.

Structure
REQ-025 COMMA, ACTIVE_CNT defaults and state encodings (SEARCH=2'd0, ALIGN=2'd1, ACTIVE=2'd2) SHALL live in the shared phy_rx definitions include file.
REQ-026 The block SHALL be one module, no sub-modules; synthesized netlist SHALL be compared cycle-for-cycle against behavioural RTL in the bench.

Verification
REQ-027 Reset 2 cycles, then 4 x 8'hBC, then 8'hA5 -> active rises on edge of 4th BC's last bit; 8 cycles later data_out = 8'hA5, valid_out = 1, byte_stb pulse.
REQ-028 3 bits of 3'b101 then 4 x 8'hBC then 8'h3C -> lock occurs despite misaligned start; data_out = 8'h3C, valid_out = 1.
REQ-029 3 x 8'hBC, 8'h12, 4 x 8'hBC, 8'h77 -> back to SEARCH after 8'h12 (active = 0, no byte_stb); active after second BC run; data_out = 8'h77.
REQ-030 In ACTIVE, stream 8'h01, 8'hBC, 8'hFF -> valid_out 1, 0, 1; data_out 8'h01, 8'hBC, 8'hFF; one byte_stb per byte, outputs stable between.
REQ-031 In ACTIVE, reset asserted at bit 4 of a byte for 1 cycle -> all outputs 0 next edge; relock requires 4 new BCs.
REQ-032 In ACTIVE, send 8'h0B then 8'hC0 (contains BC across boundary) -> no realignment; data_out 8'h0B then 8'hC0, valid_out = 1.
